hvpp_programmer: RTL and testbench
==================================

HVPP_PROGRAMMER -- requirements
Module: hvpp_programmer

Interface
REQ-001 SHALL have parameter PULSE_CYC, default 4, meaning clk cycles per XTAL1/WR/OE phase (min 2).
REQ-002 SHALL have parameter RDY_TIMEOUT, default 65535, meaning max clk cycles to wait for RDY high.
REQ-003 SHALL have clk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have cmd_valid, input, 1, host request valid.
REQ-006 SHALL have cmd_ready, output, 1, high only in IDLE.
REQ-007 SHALL have cmd_op, input, 2: 00 chip erase, 01 load word, 10 program page, 11 read word.
REQ-008 SHALL have cmd_addr, input, 14, word address, and cmd_wdata, input, 16, write word.
REQ-009 SHALL have rsp_valid, output, 1, one-cycle pulse at command completion; rsp_rdata, output, 16; rsp_err, output, 1, timeout flag.
REQ-010 SHALL have XA, output, 2; BS1, output, 1; XTAL1, output, 1; WR, output, 1, active low; OE, output, 1, active low.
REQ-011 SHALL have DATA_out, output, 8; DATA_oe, output, 1; DATA_in, input, 8; RDY, input, 1.

Function
REQ-012 SHALL accept a command on the cycle where cmd_valid and cmd_ready are both high, registering op/addr/wdata.
REQ-013 SHALL perform every load as: drive XA/BS1/DATA_out with DATA_oe=1 for PULSE_CYC cycles, then XTAL1=1 for PULSE_CYC cycles, then XTAL1=0 for PULSE_CYC cycles.
REQ-014 SHALL encode XA as 00 address (BS1=0 low byte, BS1=1 high byte), 01 data (BS1 selects byte), 10 command, 11 idle.
REQ-015 SHALL sequence chip erase as: load command 0x80, WR low PULSE_CYC cycles, wait RDY.
REQ-016 SHALL sequence load word as: load command 0x10, address low = addr[7:0], address high = {2'b0,addr[13:8]}, data low = wdata[7:0], data high = wdata[15:8]; no WR pulse.
REQ-017 SHALL sequence program page as: WR low PULSE_CYC cycles, wait RDY.
REQ-018 SHALL sequence read word as: load command 0x02, address low, address high, DATA_oe=0, OE=0, BS1=0, sample DATA_in into rdata[7:0] after PULSE_CYC cycles, BS1=1, sample rdata[15:8] after PULSE_CYC cycles, OE=1.
REQ-019 SHALL use states IDLE, LOAD_SETUP, XTAL_HI, XTAL_LO, WR_PULSE, WAIT_RDY, READ_LO, READ_HI, DONE; a step counter selects the next load within a command.
REQ-020 SHALL in WAIT_RDY first wait one PULSE_CYC period, then complete when RDY=1; a cycle counter saturating at RDY_TIMEOUT sets rsp_err=1 and completes.
REQ-021 SHALL never assert DATA_oe=1 while OE=0; DATA_oe drops one cycle before OE falls and rises one cycle after OE rises.
REQ-022 SHALL hold rsp_rdata until the next read completes; rsp_err clears on the next accepted command.
REQ-023 SHALL ignore cmd_valid while busy; no queuing.
REQ-024 SHALL drive XA=11, BS1=0 in IDLE and DONE.

Reset
REQ-025 SHALL on rst_n=0 immediately force IDLE, cmd_ready=0 during reset and 1 after, rsp_valid=0, rsp_rdata=0, rsp_err=0, XA=11, BS1=0, XTAL1=0, WR=1, OE=1, DATA_out=0, DATA_oe=0, counters 0.
REQ-026 SHALL abort any in-flight command on reset with no rsp_valid.

Structure
REQ-027 SHALL place op encodings, HVPP command bytes (0x80, 0x10, 0x02), XA encodings and the state enum in shared package hvpp_pkg.
REQ-028 SHALL implement the PULSE_CYC phase timer as sub-module hvpp_phase_timer (start, done pulse).

Verification
REQ-029 SHALL show that load word addr=0x2A5, wdata=0xBEEF yields XTAL1 pulses with (XA,BS1,DATA) = (10,0,0x10),(00,0,0xA5),(00,1,0x02),(01,0,0xEF),(01,1,0xBE), then rsp_valid.
REQ-030 SHALL show that program page with RDY held low 100 cycles yields WR low PULSE_CYC cycles, then rsp_valid exactly one cycle after RDY rises, rsp_err=0.
REQ-031 SHALL show that read word addr=0x0010 against memory 0x1234 yields rsp_rdata=0x1234, with DATA_oe=0 throughout OE=0.
REQ-032 SHALL show that chip erase with RDY stuck low and RDY_TIMEOUT=50 yields rsp_valid with rsp_err=1 after timeout.
REQ-033 SHALL show that rst_n asserted mid-XTAL_HI yields XTAL1=0, WR=1, OE=1 asynchronously, no rsp_valid, and cmd_ready=1 after release.
REQ-034 SHALL show that cmd_valid held high while busy yields exactly one accepted command.

Source files
------------

// File: rtl/hvpp_pkg.sv
// Shared encodings for the AVR high-voltage parallel programming sequencer:
// host opcodes, HVPP command bytes, XA field values, FSM states and the load table.
package hvpp_pkg;

   typedef enum logic [1:0] {
      OP_ERASE = 2'b00,
      OP_LOAD  = 2'b01,
      OP_PROG  = 2'b10,
      OP_READ  = 2'b11
   } op_t;

   localparam logic [7:0] CMD_ERASE       = 8'h80;
   localparam logic [7:0] CMD_WRITE_FLASH = 8'h10;
   localparam logic [7:0] CMD_READ_FLASH  = 8'h02;

   typedef enum logic [1:0] {
      XA_ADDR = 2'b00,
      XA_DATA = 2'b01,
      XA_CMD  = 2'b10,
      XA_IDLE = 2'b11
   } xa_t;

   typedef enum logic [3:0] {
      IDLE,
      LOAD_SETUP,
      XTAL_HI,
      XTAL_LO,
      WR_PULSE,
      WAIT_RDY,
      READ_LO,
      READ_HI,
      DONE
   } state_t;

   typedef struct packed {
      xa_t        xa;
      logic       bs1;
      logic [7:0] data;
   } load_t;

   // Number of XTAL1 loads issued before the op's WR/read/finish phase.
   function automatic logic [2:0] load_count(input op_t op);
      case (op)
         OP_ERASE: return 3'd1;
         OP_LOAD:  return 3'd5;
         OP_READ:  return 3'd3;
         default:  return 3'd0;
      endcase
   endfunction

   function automatic load_t load_step(input op_t op, input logic [2:0] step,
                                       input logic [13:0] addr, input logic [15:0] wdata);
      load_t ld;
      ld = '{xa: XA_IDLE, bs1: 1'b0, data: 8'h00};
      case (step)
         3'd0: begin
            ld.xa   = XA_CMD;
            ld.data = (op == OP_ERASE) ? CMD_ERASE :
                      (op == OP_READ)  ? CMD_READ_FLASH : CMD_WRITE_FLASH;
         end
         3'd1: begin
            ld.xa   = XA_ADDR;
            ld.data = addr[7:0];
         end
         3'd2: begin
            ld.xa   = XA_ADDR;
            ld.bs1  = 1'b1;
            ld.data = {2'b00, addr[13:8]};
         end
         3'd3: begin
            ld.xa   = XA_DATA;
            ld.data = wdata[7:0];
         end
         3'd4: begin
            ld.xa   = XA_DATA;
            ld.bs1  = 1'b1;
            ld.data = wdata[15:8];
         end
         default: ;
      endcase
      return ld;
   endfunction

endpackage

// File: rtl/hvpp_phase_timer.sv
// Phase timer: after a start pulse, done is high on the PULSE_CYC-th cycle.
// A start on the done cycle begins the next phase back to back.
module hvpp_phase_timer #(
   parameter int PULSE_CYC = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic done
);

   localparam int W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

   logic [W-1:0] cnt;
   logic         active;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         active <= 1'b0;
      end else if (start) begin
         cnt    <= '0;
         active <= 1'b1;
      end else if (active) begin
         if (cnt == W'(PULSE_CYC - 1)) active <= 1'b0;
         else                          cnt    <= cnt + W'(1);
      end
   end

   assign done = active && (cnt == W'(PULSE_CYC - 1));

endmodule

// File: rtl/hvpp_programmer.sv
// HVPP sequencer: turns host erase/load/program/read commands into XA/BS1/XTAL1/WR/OE
// pin sequences with PULSE_CYC-cycle phases and a bounded wait on RDY.
module hvpp_programmer
   import hvpp_pkg::*;
#(
   parameter int PULSE_CYC   = 4,
   parameter int RDY_TIMEOUT = 65535
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [13:0] cmd_addr,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic [1:0]  XA,
   output logic        BS1,
   output logic        XTAL1,
   output logic        WR,
   output logic        OE,
   output logic [7:0]  DATA_out,
   output logic        DATA_oe,
   input  logic [7:0]  DATA_in,
   input  logic        RDY,
   output state_t      dbg_state
);

   localparam int CNT_W = $clog2(RDY_TIMEOUT + 1);

   state_t          state, state_n;
   op_t             op_q;
   logic [13:0]     addr_q;
   logic [15:0]     wdata_q;
   logic [2:0]      step_q, step_n;
   logic [7:0]      rdata_lo;
   logic [CNT_W-1:0] rdy_cnt;
   logic            rdy_armed;
   logic            tmr_start, tmr_done;
   logic            last_load, timeout;
   load_t           ld;

   hvpp_phase_timer #(.PULSE_CYC(PULSE_CYC)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .start (tmr_start),
      .done  (tmr_done)
   );

   // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are
   // both high; cmd_ready is high only in IDLE, so requests while busy are simply ignored.
   assign cmd_ready = (state == IDLE) && rst_n;
   assign rsp_valid = (state == DONE);
   assign dbg_state = state;
   assign ld        = load_step(op_q, step_q, addr_q, wdata_q);
   assign last_load = (3'(step_q + 3'd1) == load_count(op_q));
   assign timeout   = (state == WAIT_RDY) && !(rdy_armed && RDY) &&
                      (rdy_cnt == CNT_W'(RDY_TIMEOUT));

   always_comb begin
      state_n   = state;
      step_n    = step_q;
      tmr_start = 1'b0;
      XA        = XA_IDLE;
      BS1       = 1'b0;
      XTAL1     = 1'b0;
      WR        = 1'b1;
      OE        = 1'b1;
      DATA_out  = 8'h00;
      DATA_oe   = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               step_n    = 3'd0;
               tmr_start = 1'b1;
               state_n   = (op_t'(cmd_op) == OP_PROG) ? WR_PULSE : LOAD_SETUP;
            end
         end
         LOAD_SETUP, XTAL_HI, XTAL_LO: begin
            XA       = ld.xa;
            BS1      = ld.bs1;
            DATA_out = ld.data;
            DATA_oe  = 1'b1;
            XTAL1    = (state == XTAL_HI);
            if (tmr_done) begin
               tmr_start = 1'b1;
               if (state == LOAD_SETUP) state_n = XTAL_HI;
               else if (state == XTAL_HI) state_n = XTAL_LO;
               else if (!last_load) begin
                  step_n  = 3'(step_q + 3'd1);
                  state_n = LOAD_SETUP;
               end else begin
                  case (op_q)
                     OP_ERASE: state_n = WR_PULSE;
                     OP_READ: begin
                        // Release the bus one cycle before OE falls in READ_LO.
                        state_n = READ_LO;
                        DATA_oe = 1'b0;
                     end
                     default: begin
                        state_n   = DONE;
                        tmr_start = 1'b0;
                     end
                  endcase
               end
            end
         end
         WR_PULSE: begin
            WR = 1'b0;
            if (tmr_done) begin
               state_n   = WAIT_RDY;
               tmr_start = 1'b1;
            end
         end
         WAIT_RDY: begin
            if ((rdy_armed && RDY) || timeout) state_n = DONE;
         end
         READ_LO: begin
            OE = 1'b0;
            if (tmr_done) begin
               state_n   = READ_HI;
               tmr_start = 1'b1;
            end
         end
         READ_HI: begin
            OE  = 1'b0;
            BS1 = 1'b1;
            if (tmr_done) state_n = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_q      <= OP_ERASE;
         addr_q    <= '0;
         wdata_q   <= '0;
         step_q    <= '0;
         rdata_lo  <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         rdy_cnt   <= '0;
         rdy_armed <= 1'b0;
      end else begin
         state  <= state_n;
         step_q <= step_n;
         if (state == IDLE && cmd_valid && cmd_ready) begin
            op_q    <= op_t'(cmd_op);
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            rsp_err <= 1'b0;
         end
         // RDY is ignored for one phase after WR so the target has time to pull it low.
         if (state == WAIT_RDY) begin
            if (tmr_done) rdy_armed <= 1'b1;
            if (rdy_cnt != CNT_W'(RDY_TIMEOUT)) rdy_cnt <= rdy_cnt + CNT_W'(1);
            if (timeout) rsp_err <= 1'b1;
         end else begin
            rdy_cnt   <= '0;
            rdy_armed <= 1'b0;
         end
         if (state == READ_LO && tmr_done) rdata_lo  <= DATA_in;
         if (state == READ_HI && tmr_done) rsp_rdata <= {DATA_in, rdata_lo};
      end
   end

endmodule

// File: tb/tb_hvpp_programmer.sv
// Bench for hvpp_programmer: directed commands with hand-computed pin loads and
// responses queued for monitors, plus a second instance with a short RDY timeout.
module tb_hvpp_programmer;
   import hvpp_pkg::*;

   localparam int P = 4;

   logic        clk, rst_n;
   logic        cmd_valid, t_cmd_valid;
   logic [1:0]  cmd_op;
   logic [13:0] cmd_addr;
   logic [15:0] cmd_wdata;
   logic        rdy;
   logic [15:0] mem_word;

   logic        cmd_ready, rsp_valid, rsp_err;
   logic [15:0] rsp_rdata;
   logic [1:0]  xa;
   logic        bs1, xtal1, wr, oe, data_oe;
   logic [7:0]  data_out, data_in;
   state_t      dbg_state;

   logic        t_cmd_ready, t_rsp_valid, t_rsp_err;
   logic [15:0] t_rsp_rdata;
   logic [1:0]  t_xa;
   logic        t_bs1, t_xtal1, t_wr, t_oe, t_data_oe;
   logic [7:0]  t_data_out;
   state_t      t_dbg_state;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [16:0] exp_q[$];
   logic [16:0] t_exp_q[$];
   logic [10:0] exp_ld_q[$];
   logic [16:0] mon_e, t_mon_e;
   logic [10:0] ld_e;
   logic        prev_xtal1 = 1'b0;
   logic        prev_oe = 1'b1;
   logic        prev_doe = 1'b0;
   int          wr_cnt = 0;
   int          n, lat, acc;
   logic        early, seen;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   // Target memory returns the addressed word byte selected by BS1 while OE is low.
   assign data_in = !oe ? (bs1 ? mem_word[15:8] : mem_word[7:0]) : 8'h00;

   hvpp_programmer dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .XA(xa), .BS1(bs1), .XTAL1(xtal1), .WR(wr), .OE(oe),
      .DATA_out(data_out), .DATA_oe(data_oe), .DATA_in(data_in), .RDY(rdy),
      .dbg_state(dbg_state)
   );

   hvpp_programmer #(.PULSE_CYC(P), .RDY_TIMEOUT(50)) dut_t (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata), .rsp_err(t_rsp_err),
      .XA(t_xa), .BS1(t_bs1), .XTAL1(t_xtal1), .WR(t_wr), .OE(t_oe),
      .DATA_out(t_data_out), .DATA_oe(t_data_oe), .DATA_in(8'h00), .RDY(1'b0),
      .dbg_state(t_dbg_state)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- monitors / scoreboard ----------------
   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rsp_unexpected: got rdata=0x%h err=%b, required no response", rsp_rdata, rsp_err);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, mon_e[16:1]);
            chk("rsp_err", rsp_err, mon_e[0]);
         end
      end
      if (rst_n && t_rsp_valid) begin
         if (t_exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL t_rsp_unexpected: got rdata=0x%h err=%b, required no response", t_rsp_rdata, t_rsp_err);
         end else begin
            t_mon_e = t_exp_q.pop_front();
            chk("t_rsp_rdata", t_rsp_rdata, t_mon_e[16:1]);
            chk("t_rsp_err", t_rsp_err, t_mon_e[0]);
         end
      end
   end

   always @(negedge clk) begin
      if (xtal1 && !prev_xtal1) begin
         if (exp_ld_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL load_unexpected: got xa=%b bs1=%b data=0x%h, required no load", xa, bs1, data_out);
         end else begin
            ld_e = exp_ld_q.pop_front();
            chk("load_xa_bs1_data", {xa, bs1, data_out}, ld_e);
            chk("load_data_oe", data_oe, 1'b1);
         end
      end
      prev_xtal1 = xtal1;
   end

   always @(negedge clk) begin
      if (!oe) chk("data_oe_while_oe_low", data_oe, 1'b0);
      if (prev_oe && !oe) chk("data_oe_before_oe_fall", prev_doe, 1'b0);
      if (!prev_oe && oe) chk("data_oe_at_oe_rise", data_oe, 1'b0);
      prev_oe  = oe;
      prev_doe = data_oe;
      if (!wr) wr_cnt++;
      else if (wr_cnt != 0) begin
         chk("wr_low_width", wr_cnt, P);
         wr_cnt = 0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [1:0] op, input logic [13:0] addr, input logic [15:0] wd);
      int k;
      @(negedge clk);
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_wdata = wd;
      cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 1000) begin
         @(negedge clk);
         k++;
      end
      if (!cmd_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout: cmd_ready=0 after %0d cycles, required 1", k);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("rsp_outstanding", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic t_issue_erase();
      int k;
      @(negedge clk);
      cmd_op      = 2'b00;
      t_cmd_valid = 1'b1;
      k = 0;
      while (!t_cmd_ready && k < 1000) begin
         @(negedge clk);
         k++;
      end
      if (!t_cmd_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL t_accept_timeout: cmd_ready=0 after %0d cycles, required 1", k);
      end
      @(negedge clk);
      t_cmd_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n       = 1'b0;
      cmd_valid   = 1'b0;
      t_cmd_valid = 1'b0;
      cmd_op      = 2'b00;
      cmd_addr    = '0;
      cmd_wdata   = '0;
      rdy         = 1'b1;
      mem_word    = '0;
      repeat (3) @(negedge clk);
      chk("reset_cmd_ready", cmd_ready, 1'b0);
      chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 18'h0);
      chk("reset_bus", {xa, bs1, xtal1, wr, oe, data_out, data_oe},
          {2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0});
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", cmd_ready, 1'b1);
      chk("state_after_reset", dbg_state, IDLE);

      // load word 0x2A5 / 0xBEEF
      exp_ld_q.push_back({2'b10, 1'b0, 8'h10});
      exp_ld_q.push_back({2'b00, 1'b0, 8'hA5});
      exp_ld_q.push_back({2'b00, 1'b1, 8'h02});
      exp_ld_q.push_back({2'b01, 1'b0, 8'hEF});
      exp_ld_q.push_back({2'b01, 1'b1, 8'hBE});
      exp_q.push_back({16'h0000, 1'b0});
      issue(2'b01, 14'h02A5, 16'hBEEF);
      wait_done();
      chk("idle_bus", {xa, bs1, data_oe}, {2'b11, 1'b0, 1'b0});

      // chip erase with RDY already high
      exp_ld_q.push_back({2'b10, 1'b0, 8'h80});
      exp_q.push_back({16'h0000, 1'b0});
      issue(2'b00, 14'h0000, 16'h0000);
      wait_done();

      // program page, RDY low for 100 cycles
      rdy = 1'b0;
      exp_q.push_back({16'h0000, 1'b0});
      issue(2'b10, 14'h0000, 16'h0000);
      early = 1'b0;
      repeat (100) begin
         @(negedge clk);
         early |= rsp_valid;
      end
      chk("prog_no_early_rsp", early, 1'b0);
      rdy = 1'b1;
      @(negedge clk);
      chk("prog_rsp_one_cycle_after_rdy", rsp_valid, 1'b1);
      chk("prog_err", rsp_err, 1'b0);
      wait_done();

      // read word 0x0010 -> 0x1234
      mem_word = 16'h1234;
      exp_ld_q.push_back({2'b10, 1'b0, 8'h02});
      exp_ld_q.push_back({2'b00, 1'b0, 8'h10});
      exp_ld_q.push_back({2'b00, 1'b1, 8'h00});
      exp_q.push_back({16'h1234, 1'b0});
      issue(2'b11, 14'h0010, 16'h0000);
      wait_done();
      chk("read1_rdata_held", rsp_rdata, 16'h1234);

      // read word at the top address -> 0xA55A
      mem_word = 16'hA55A;
      exp_ld_q.push_back({2'b10, 1'b0, 8'h02});
      exp_ld_q.push_back({2'b00, 1'b0, 8'hFF});
      exp_ld_q.push_back({2'b00, 1'b1, 8'h3F});
      exp_q.push_back({16'hA55A, 1'b0});
      issue(2'b11, 14'h3FFF, 16'h0000);
      wait_done();

      // all-zero load word; read data must stay
      exp_ld_q.push_back({2'b10, 1'b0, 8'h10});
      exp_ld_q.push_back({2'b00, 1'b0, 8'h00});
      exp_ld_q.push_back({2'b00, 1'b1, 8'h00});
      exp_ld_q.push_back({2'b01, 1'b0, 8'h00});
      exp_ld_q.push_back({2'b01, 1'b1, 8'h00});
      exp_q.push_back({16'hA55A, 1'b0});
      issue(2'b01, 14'h0000, 16'h0000);
      wait_done();

      // chip erase with RDY stuck low on the 50-cycle timeout instance
      t_exp_q.push_back({16'h0000, 1'b1});
      t_issue_erase();
      lat = 1;
      while (!t_rsp_valid && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      chk("t_timeout_latency", lat, 68);
      @(negedge clk);
      chk("t_err_held", t_rsp_err, 1'b1);
      t_exp_q.push_back({16'h0000, 1'b1});
      t_issue_erase();
      chk("t_err_cleared_on_accept", t_rsp_err, 1'b0);
      n = 0;
      while (t_exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("t_rsp_outstanding", t_exp_q.size(), 0);
      @(negedge clk);
      chk("t_idle_bus", {t_xa, t_bs1, t_xtal1, t_wr, t_oe, t_data_out, t_data_oe},
          {2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0});
      chk("t_state_idle", t_dbg_state, IDLE);

      // cmd_valid held high through a whole command
      exp_ld_q.push_back({2'b10, 1'b0, 8'h10});
      exp_ld_q.push_back({2'b00, 1'b0, 8'h55});
      exp_ld_q.push_back({2'b00, 1'b1, 8'h15});
      exp_ld_q.push_back({2'b01, 1'b0, 8'h34});
      exp_ld_q.push_back({2'b01, 1'b1, 8'h12});
      exp_q.push_back({16'hA55A, 1'b0});
      @(negedge clk);
      cmd_op    = 2'b01;
      cmd_addr  = 14'h1555;
      cmd_wdata = 16'h1234;
      cmd_valid = 1'b1;
      acc = 0;
      n   = 0;
      while (!rsp_valid && n < 500) begin
         if (cmd_valid && cmd_ready) acc++;
         @(negedge clk);
         n++;
      end
      cmd_valid = 1'b0;
      chk("busy_single_accept", acc, 1);
      chk("busy_rsp_seen", rsp_valid, 1'b1);
      wait_done();

      // reset during XTAL_HI of a load word
      exp_ld_q.push_back({2'b10, 1'b0, 8'h10});
      issue(2'b01, 14'h0123, 16'h4567);
      n = 0;
      while (!xtal1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reached_xtal_hi", xtal1, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_async_pins", {xtal1, wr, oe, rsp_valid, cmd_ready},
          {1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      chk("abort_state", dbg_state, IDLE);
      @(negedge clk);
      @(negedge clk);
      exp_ld_q.delete();
      exp_q.delete();
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_ready_after_release", cmd_ready, 1'b1);
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         seen |= rsp_valid;
      end
      chk("abort_no_rsp", seen, 1'b0);

      chk("queues_drained", exp_q.size() + t_exp_q.size() + exp_ld_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
